mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between EX and WB. It latches the EX→MEM bus and tracks the outstanding data-SRAM request of a load/store. It aligns and extends load data, then hands a 242-bit bus to WB over the valid/allowin handshake. On a WB exception or ERTN flush it drops its instruction and discards SRAM responses that belong to killed instructions. It also drives the forwarding/hazard bus back to ID.

## Interface
No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_allowin  out  1  stage can accept from EX
- ex_mem_valid  in  1  EX holds a valid instruction
- ex_mem_bus  in  242  WB-layout payload; field [176:145] holds the ALU result or memory address
- ex_mem_info  in  5  {mem_req, mem_ld, ld_size[1:0] (00 B, 01 H, 10 W), ld_unsigned}; mem_req=1 means EX's SRAM request was accepted
- data_sram_data_ok  in  1  response strobe
- data_sram_rdata  in  32  response data
- wb_allowin  in  1  WB can accept
- mem_wb_valid  out  1  valid to WB
- mem_wb_bus  out  242  payload to WB
- wb_ex  in  1  WB exception flush
- ertn_flush  in  1  WB ERTN flush
- mem_ex  out  1  MEM holds an exception or ERTN; EX must suppress new requests
- mem_id_bus  out  39  {fwd_we, fwd_dest[4:0], fwd_data[31:0], ld_block}

Bus bit map, shared with WB:
- gr_we 241, pc 240:209, inst 208:177, result 176:145, dest 144:140
- csr_we 139, csr_re 138, csr_num 137:124, csr_wmask 123:92, csr_wvalue 91:60
- ertn 59, syscall 58, wrong_addr 57:26, ex_id 25, esubcode 24:16, ecode 15:10
- tlbsrch 9, tlbrd 8, tlbwr 7, tlbfill 6, invtlb 5, s1_found 4, s1_index 3:0

## Operation
- Registers:
  - mem_valid, bus_r[241:0], info_r[4:0]
  - resp_vld (response already buffered for the current instruction), resp_data[31:0]
  - cancel_cnt[1:0] (responses still to discard)
- flush = wb_ex | ertn_flush.
- mem_valid update, in priority order:
  - reset → 0
  - flush → 0
  - mem_allowin → ex_mem_valid
- bus_r and info_r load when ex_mem_valid & mem_allowin.
- resp_vld clears whenever bus_r loads.
- Response ownership: a data_ok with cancel_cnt≠0 is discarded and decrements cancel_cnt. Otherwise, if mem_valid & info_r.mem_req & ~resp_vld, it sets resp_vld and captures rdata.
- cancel_cnt on flush: increments by (mem_valid & info_r.mem_req & ~resp_vld & ~own_ok), where own_ok is a data_ok claimed this same cycle, plus (ex_mem_valid & ex_mem_info.mem_req). Net change with a simultaneous discard is +inc−1. Saturates at 3.
- ready_go = ~info_r.mem_req | resp_vld | own_ok.
- mem_allowin = ~mem_valid | (ready_go & wb_allowin).
- mem_wb_valid = mem_valid & ready_go & ~flush.
- raw = resp_vld ? resp_data : data_sram_rdata. Byte offset a = result[1:0].
  - B: raw[8a+7:8a], zero- or sign-extended.
  - H: raw[16a[1]+15:16a[1]], zero- or sign-extended.
  - W: raw.
- mem_wb_bus is bus_r with [176:145] replaced by the load result when info_r.mem_ld; all other fields pass unchanged.
- mem_ex = mem_valid & (bus_r[25] | bus_r[59]).
- mem_id_bus:
  - fwd_we = mem_valid & bus_r[241]
  - fwd_dest = bus_r[144:140]
  - fwd_data = the outgoing result field
  - ld_block = mem_valid & (info_r.mem_ld | bus_r[138] | bus_r[139]) & ~(info_r.mem_ld & ready_go & ~bus_r[138] & ~bus_r[139])

## Timing
- Reset values: mem_valid=0, mem_wb_valid=0, resp_vld=0, cancel_cnt=0, mem_ex=0, fwd_we=0, ld_block=0. mem_allowin=1 one cycle after reset deasserts.
- Latency:
  - Non-memory instruction: 1 cycle in MEM.
  - Memory instruction: until its own data_ok arrives. A same-cycle data_ok passes combinationally to mem_wb_valid and the bus.
- A response arriving while WB stalls is held in resp_data, never lost.
- A flush in the same cycle as a valid EX handoff blocks entry.
- A data_ok arriving at a stall or pipeline bubble with cancel_cnt=0 is ignored, which cannot occur per protocol.

## Test plan
- ld.b at address offset 3, rdata=0x80FF_1234, data_ok 2 cycles after entry → mem_wb_valid pulses 2 cycles after entry with result 0xFFFF_FF80; ld.bu gives 0x0000_0080.
- ld.h at offset 2 with rdata=0x8001_7FFF → 0xFFFF_8001; ld.w returns rdata unchanged; add passes result in 1 cycle.
- data_ok=0x1122_3344 arrives while wb_allowin=0 for 3 cycles → the value is held; it is sent as 0x1122_3344 on the first cycle wb_allowin=1.
- Load in MEM with no response, and EX handing off a load with mem_req=1, when wb_ex pulses → mem_valid=0, cancel_cnt=2. The next two data_ok pulses are discarded; a following load's data_ok is accepted.
- Flush in the same cycle as data_ok for the current load → cancel_cnt stays 0 and nothing reaches WB.
- Reset asserted mid-wait with cancel_cnt=1 → every register returns to its reset value the next cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX->MEM->WB handshake, data-SRAM response and ID forwarding signals of the MEM stage.
// The slave modport is the stage itself; master is the surrounding pipeline and memory.
interface mem_stage_if;
    logic         mem_allowin;
    logic         ex_mem_valid;
    logic [241:0] ex_mem_bus;
    logic [4:0]   ex_mem_info;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         wb_allowin;
    logic         mem_wb_valid;
    logic [241:0] mem_wb_bus;
    logic         wb_ex;
    logic         ertn_flush;
    logic         mem_ex;
    logic [38:0]  mem_id_bus;

    modport slave (
        input  ex_mem_valid, ex_mem_bus, ex_mem_info,
        input  data_sram_data_ok, data_sram_rdata,
        input  wb_allowin, wb_ex, ertn_flush,
        output mem_allowin, mem_wb_valid, mem_wb_bus, mem_ex, mem_id_bus
    );

    modport master (
        output ex_mem_valid, ex_mem_bus, ex_mem_info,
        output data_sram_data_ok, data_sram_rdata,
        output wb_allowin, wb_ex, ertn_flush,
        input  mem_allowin, mem_wb_valid, mem_wb_bus, mem_ex, mem_id_bus
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EX->MEM instruction, waits for its data-SRAM response,
// aligns load data and discards responses owned by instructions killed by a WB flush.
module mem_stage (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave mif
);
    localparam int GR_WE_BIT  = 241;
    localparam int RES_MSB    = 176;
    localparam int RES_LSB    = 145;
    localparam int DEST_MSB   = 144;
    localparam int DEST_LSB   = 140;
    localparam int CSR_WE_BIT = 139;
    localparam int CSR_RE_BIT = 138;
    localparam int ERTN_BIT   = 59;
    localparam int EX_ID_BIT  = 25;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef struct packed {
        logic       mem_req;
        logic       mem_ld;
        logic [1:0] ld_size;
        logic       ld_unsigned;
    } mem_info_t;

    logic         mem_valid_q, mem_valid_d;
    logic [241:0] bus_q, bus_d;
    mem_info_t    info_q, info_d;
    logic         resp_vld_q, resp_vld_d;
    logic [31:0]  resp_data_q, resp_data_d;
    logic [1:0]   cancel_cnt_q, cancel_cnt_d;

    mem_info_t    ex_info;
    logic         flush, discard, own_ok, ready_go, allowin, load_bus, csr_acc, ld_block;
    logic [1:0]   cancel_inc;
    logic [2:0]   cancel_sum;
    logic [1:0]   byte_off;
    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;
    logic [31:0]  raw, ld_data, result;

    assign flush    = mif.wb_ex | mif.ertn_flush;
    assign ex_info  = mem_info_t'(mif.ex_mem_info);
    assign discard  = mif.data_sram_data_ok & (cancel_cnt_q != 2'd0);
    assign own_ok   = mif.data_sram_data_ok & (cancel_cnt_q == 2'd0)
                    & mem_valid_q & info_q.mem_req & ~resp_vld_q;
    assign ready_go = ~info_q.mem_req | resp_vld_q | own_ok;
    assign allowin  = ~mem_valid_q | (ready_go & mif.wb_allowin);
    assign load_bus = mif.ex_mem_valid & allowin;

    always_comb begin
        // NOTE: every target gets a default first, so no branch can leave one unassigned and infer a latch.
        mem_valid_d = mem_valid_q;
        bus_d       = bus_q;
        info_d      = info_q;
        resp_vld_d  = resp_vld_q;
        resp_data_d = resp_data_q;
        cancel_inc  = 2'd0;

        if (flush)        mem_valid_d = 1'b0;
        else if (allowin) mem_valid_d = mif.ex_mem_valid;

        if (load_bus) begin
            bus_d      = mif.ex_mem_bus;
            info_d     = ex_info;
            resp_vld_d = 1'b0;
        end else if (own_ok) begin
            resp_vld_d = 1'b1;
        end
        if (own_ok) resp_data_d = mif.data_sram_rdata;

        // Each killed instruction whose request is still in flight owes one response to drop.
        if (flush) begin
            cancel_inc = {1'b0, mem_valid_q & info_q.mem_req & ~resp_vld_q & ~own_ok}
                       + {1'b0, mif.ex_mem_valid & ex_info.mem_req};
        end
        cancel_sum   = {1'b0, cancel_cnt_q} + {1'b0, cancel_inc} - {2'b00, discard};
        cancel_cnt_d = (cancel_sum > 3'd3) ? 2'd3 : cancel_sum[1:0];
    end

    always_comb begin
        raw      = resp_vld_q ? resp_data_q : mif.data_sram_rdata;
        byte_off = bus_q[RES_LSB +: 2];
        ld_byte  = raw[{byte_off, 3'b000} +: 8];
        ld_half  = byte_off[1] ? raw[31:16] : raw[15:0];
        case (info_q.ld_size)
            SZ_B:    ld_data = {{24{ld_byte[7] & ~info_q.ld_unsigned}}, ld_byte};
            SZ_H:    ld_data = {{16{ld_half[15] & ~info_q.ld_unsigned}}, ld_half};
            default: ld_data = raw;
        endcase
        result = info_q.mem_ld ? ld_data : bus_q[RES_MSB:RES_LSB];
    end

    assign csr_acc  = bus_q[CSR_RE_BIT] | bus_q[CSR_WE_BIT];
    assign ld_block = mem_valid_q & (info_q.mem_ld | csr_acc)
                    & ~(info_q.mem_ld & ready_go & ~csr_acc);

    assign mif.mem_allowin  = allowin;
    assign mif.mem_wb_valid = mem_valid_q & ready_go & ~flush;
    assign mif.mem_wb_bus   = {bus_q[241:RES_MSB+1], result, bus_q[RES_LSB-1:0]};
    assign mif.mem_ex       = mem_valid_q & (bus_q[EX_ID_BIT] | bus_q[ERTN_BIT]);
    assign mif.mem_id_bus   = {mem_valid_q & bus_q[GR_WE_BIT], bus_q[DEST_MSB:DEST_LSB], result, ld_block};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q  <= 1'b0;
            resp_vld_q   <= 1'b0;
            cancel_cnt_q <= 2'd0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            resp_vld_q   <= resp_vld_d;
            cancel_cnt_q <= cancel_cnt_d;
        end
    end

    // NOTE: payload flops carry no reset; nothing downstream trusts them while mem_valid_q is low.
    always_ff @(posedge clk) begin
        bus_q       <= bus_d;
        info_q      <= info_d;
        resp_data_q <= resp_data_d;
    end
endmodule

// File: tb/tb_mem_stage.sv
// Checks mem_stage against a transaction model that tags every SRAM request with its owner
// and drops responses whose owner a flush has killed.
module tb_mem_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if mif ();
    mem_stage dut (.clk(clk), .reset(reset), .mif(mif));

    typedef struct {
        int          owner;
        logic [31:0] data;
        bit          killed;
    } resp_t;

    resp_t        pend[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           next_id  = 0;

    bit           ex_has = 0;
    logic [241:0] ex_bus = '0;
    logic [4:0]   ex_info = '0;
    int           ex_id = 0;

    bit           in_mem = 0;
    logic [241:0] cur_bus = '0;
    logic [4:0]   cur_info = '0;
    int           cur_id = 0;
    bit           cur_has = 0;
    logic [31:0]  cur_data = '0;

    logic         obs_valid, obs_allowin;
    logic [241:0] obs_bus;

    task automatic check(input string tag, input logic [241:0] got, input logic [241:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_result(input logic [31:0] raw, input int off,
                                              input logic [1:0] size, input bit uns);
        logic [31:0] v;
        case (size)
            2'd0: begin
                v = (raw >> (8 * off)) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (raw >> (16 * (off / 2))) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = raw;
        endcase
        return v;
    endfunction

    function automatic logic [241:0] rand_bus(input logic [31:0] result);
        logic [255:0] w;
        logic [241:0] b;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        b = w[241:0];
        b[176:145] = result;
        b[25] = ($urandom_range(0, 7) == 0);
        b[59] = ($urandom_range(0, 7) == 0);
        return b;
    endfunction

    function automatic logic [4:0] rand_info();
        logic [4:0] i;
        i = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
            0: i[4:3] = 2'b00;
            1: i[4:3] = 2'b10;
            default: begin
                i[4:3] = 2'b11;
                i[2:1] = 2'($urandom_range(0, 2));
            end
        endcase
        return i;
    endfunction

    function automatic int killed_pending();
        int n = 0;
        foreach (pend[i]) if (pend[i].killed) n++;
        return n;
    endfunction

    task automatic kill(input int id);
        foreach (pend[i]) if (pend[i].owner == id) pend[i].killed = 1'b1;
    endtask

    task automatic new_ex(input logic [241:0] b, input logic [4:0] info, input logic [31:0] rdata);
        resp_t r;
        ex_has  = 1'b1;
        ex_bus  = b;
        ex_info = info;
        ex_id   = next_id++;
        if (info[4]) begin
            r.owner  = ex_id;
            r.data   = rdata;
            r.killed = 1'b0;
            pend.push_back(r);
        end
    endtask

    // One clock: drive, compare, advance the model. want_ok delivers the oldest response
    // only when the protocol allows it (killed owner, or owner waiting in MEM).
    task automatic step(input bit rst, input bit wb_al, input bit fl, input bit want_ok);
        bit           ok, own, ready, exp_allowin, exp_valid, csr_acc, ld;
        logic [31:0]  rdata, raw, res;
        logic [241:0] exp_bus;
        @(negedge clk);
        ok = !rst && want_ok && pend.size() > 0 &&
             (pend[0].killed || (in_mem && pend[0].owner == cur_id && !cur_has));
        rdata = ok ? pend[0].data : $urandom;
        reset                 = rst;
        mif.ex_mem_valid      = ex_has;
        mif.ex_mem_bus        = ex_bus;
        mif.ex_mem_info       = ex_info;
        mif.wb_allowin        = wb_al;
        mif.wb_ex             = 1'b0;
        mif.ertn_flush        = 1'b0;
        if (fl) begin
            if ($urandom_range(0, 1) == 1) mif.wb_ex = 1'b1;
            else                           mif.ertn_flush = 1'b1;
        end
        mif.data_sram_data_ok = ok;
        mif.data_sram_rdata   = rdata;
        #1;
        own         = ok && !pend[0].killed;
        ld          = cur_info[3];
        ready       = !cur_info[4] || cur_has || own;
        exp_allowin = !in_mem || (ready && wb_al);
        exp_valid   = in_mem && ready && !fl;
        raw         = cur_has ? cur_data : rdata;
        res         = ld ? ld_result(raw, int'(cur_bus[146:145]), cur_info[2:1], cur_info[0])
                         : cur_bus[176:145];
        exp_bus     = cur_bus;
        exp_bus[176:145] = res;
        csr_acc     = cur_bus[138] || cur_bus[139];
        obs_valid   = mif.mem_wb_valid;
        obs_allowin = mif.mem_allowin;
        obs_bus     = mif.mem_wb_bus;
        if (!rst) begin
            check("allowin", mif.mem_allowin, exp_allowin);
            check("wb_valid", mif.mem_wb_valid, exp_valid);
            if (exp_valid) check("wb_bus", mif.mem_wb_bus, exp_bus);
            check("mem_ex", mif.mem_ex, in_mem && (cur_bus[25] || cur_bus[59]));
            check("fwd_we", mif.mem_id_bus[38], in_mem && cur_bus[241]);
            check("ld_block", mif.mem_id_bus[0], in_mem && (ld || csr_acc) && !(ld && ready && !csr_acc));
            if (in_mem) check("fwd_dest_data", mif.mem_id_bus[37:1], {cur_bus[144:140], res});
        end

        if (rst) begin
            in_mem  = 1'b0;
            cur_has = 1'b0;
            ex_has  = 1'b0;
            pend.delete();
        end else begin
            if (ok) void'(pend.pop_front());
            if (fl) begin
                if (in_mem && cur_info[4] && !cur_has && !own) kill(cur_id);
                if (ex_has && ex_info[4]) kill(ex_id);
                in_mem = 1'b0;
                ex_has = 1'b0;
            end else if (exp_allowin) begin
                in_mem = ex_has;
                if (ex_has) begin
                    cur_bus  = ex_bus;
                    cur_info = ex_info;
                    cur_id   = ex_id;
                    cur_has  = 1'b0;
                    ex_has   = 1'b0;
                end
            end else if (own) begin
                cur_has  = 1'b1;
                cur_data = rdata;
            end
        end
        @(posedge clk);
    endtask

    task automatic run_load(input string tag, input logic [31:0] addr, input logic [4:0] info,
                            input logic [31:0] rdata, input logic [31:0] exp_res);
        new_ex(rand_bus(addr), info, rdata);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check({tag, "_wait"}, obs_valid, 1'b0);
        step(0, 1, 0, 1);
        check({tag, "_vld"}, obs_valid, 1'b1);
        check({tag, "_res"}, obs_bus[176:145], exp_res);
    endtask

    initial begin
        reset = 1'b1;
        mif.ex_mem_valid = 1'b0;
        mif.ex_mem_bus = '0;
        mif.ex_mem_info = '0;
        mif.data_sram_data_ok = 1'b0;
        mif.data_sram_rdata = '0;
        mif.wb_allowin = 1'b1;
        mif.wb_ex = 1'b0;
        mif.ertn_flush = 1'b0;

        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check("rst_allowin", obs_allowin, 1'b1);
        check("rst_valid", obs_valid, 1'b0);

        run_load("ld_b",  32'h0000_1003, 5'b11000, 32'h80FF_1234, 32'hFFFF_FF80);
        run_load("ld_bu", 32'h0000_1003, 5'b11001, 32'h80FF_1234, 32'h0000_0080);
        run_load("ld_h",  32'h0000_2002, 5'b11010, 32'h8001_7FFF, 32'hFFFF_8001);
        run_load("ld_w",  32'h0000_3000, 5'b11100, 32'hA5C3_0F96, 32'hA5C3_0F96);

        new_ex(rand_bus(32'h1357_9BDF), 5'b00000, 32'h0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("add_vld", obs_valid, 1'b1);
        check("add_res", obs_bus[176:145], 32'h1357_9BDF);

        // Response lands during a three-cycle WB stall and must survive it.
        new_ex(rand_bus(32'h0000_4000), 5'b11100, 32'h1122_3344);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("hold_vld", obs_valid, 1'b1);
        check("hold_res", obs_bus[176:145], 32'h1122_3344);

        // Flush kills a waiting load in MEM and a load being handed over from EX.
        new_ex(rand_bus(32'h0000_5000), 5'b11100, 32'hDEAD_0001);
        step(0, 1, 0, 0);
        new_ex(rand_bus(32'h0000_5004), 5'b11100, 32'hDEAD_0002);
        step(0, 1, 1, 0);
        check("kill_vld", obs_valid, 1'b0);
        new_ex(rand_bus(32'h0000_6000), 5'b11100, 32'h0BAD_F00D);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        check("drop1_vld", obs_valid, 1'b0);
        step(0, 1, 0, 1);
        check("drop2_vld", obs_valid, 1'b0);
        step(0, 1, 0, 1);
        check("after_drop_vld", obs_valid, 1'b1);
        check("after_drop_res", obs_bus[176:145], 32'h0BAD_F00D);

        // Flush coincides with the load's own response: nothing is owed afterwards.
        new_ex(rand_bus(32'h0000_7000), 5'b11100, 32'h5555_AAAA);
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        check("flush_ok_vld", obs_valid, 1'b0);
        run_load("post_flush", 32'h0000_7100, 5'b11100, 32'h600D_0005, 32'h600D_0005);

        // Reset while one killed response is still owed.
        new_ex(rand_bus(32'h0000_8000), 5'b11100, 32'h7777_0000);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check("mid_rst_allowin", obs_allowin, 1'b1);
        check("mid_rst_valid", obs_valid, 1'b0);
        run_load("post_rst", 32'h0000_8101, 5'b11001, 32'h0000_C300, 32'h0000_00C3);

        for (int c = 0; c < 4000; c++) begin
            if (!ex_has && $urandom_range(0, 7) < 5) new_ex(rand_bus($urandom), rand_info(), $urandom);
            step(0, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 15) == 0) && (killed_pending() <= 1),
                 $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
